// File: rtl/nanorv32_rf_wr_sched.sv
// nanorv32_rf_wr_sched: round-robin writeback arbiter onto the two regfile write ports,
// with a pending-write scoreboard for RAW hazard stalls.
module nanorv32_rf_wr_sched #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*5-1:0]  req_sel,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  reserve_valid,
    input  logic [4:0]            reserve_sel,
    input  logic [4:0]            chk_sel_a,
    input  logic [4:0]            chk_sel_b,
    output logic                  busy_a,
    output logic                  busy_b,
    input  logic                  allow_hidden_use_of_x0,
    output logic [4:0]            sel_rd,
    output logic [4:0]            sel_rd2,
    output logic [31:0]           rd,
    output logic [31:0]           rd2,
    output logic                  write_rd,
    output logic                  write_rd2
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]       rr_q, rr_d;
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [4:0]          sel_rd_q, sel_rd2_q;
    logic [31:0]         rd_q, rd2_q;
    logic                write_rd_q, write_rd2_q;
    logic                a_v, b_v;
    int                  a_idx, b_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [4:0]          sel_a, sel_b;
    logic [31:0]         data_a, data_b;

    function automatic int slot(input logic [PW-1:0] rr, input int k);
        return (int'(rr) + k) % NUM_REQ;
    endfunction

    // Slot B must target a different register than slot A so both ports never collide.
    always_comb begin
        a_v   = 1'b0;
        b_v   = 1'b0;
        a_idx = 0;
        b_idx = 0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[slot(rr_q, k)]) begin
                if (!a_v) begin
                    a_v   = 1'b1;
                    a_idx = slot(rr_q, k);
                end else if (!b_v && req_sel[5*slot(rr_q, k) +: 5] != req_sel[5*a_idx +: 5]) begin
                    b_v   = 1'b1;
                    b_idx = slot(rr_q, k);
                end
            end
        end
        if (a_v) gnt[a_idx] = 1'b1;
        if (b_v) gnt[b_idx] = 1'b1;
        sel_a  = req_sel[5*a_idx +: 5];
        sel_b  = req_sel[5*b_idx +: 5];
        data_a = req_data[32*a_idx +: 32];
        data_b = req_data[32*b_idx +: 32];
        rr_d   = b_v ? PW'((b_idx + 1) % NUM_REQ) : a_v ? PW'((a_idx + 1) % NUM_REQ) : rr_q;
    end

    // Clears come from the strobes on the port, so a newer reservation in the same cycle wins.
    always_comb begin
        sb_d = sb_q;
        if (write_rd_q) sb_d[sel_rd_q] = 1'b0;
        if (write_rd2_q) sb_d[sel_rd2_q] = 1'b0;
        if (reserve_valid && (reserve_sel != 5'd0 || allow_hidden_use_of_x0)) sb_d[reserve_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            sb_q        <= '0;
            sel_rd_q    <= '0;
            sel_rd2_q   <= '0;
            rd_q        <= '0;
            rd2_q       <= '0;
            write_rd_q  <= 1'b0;
            write_rd2_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            sb_q        <= sb_d;
            write_rd_q  <= a_v && (sel_a != 5'd0 || allow_hidden_use_of_x0);
            write_rd2_q <= b_v && (sel_b != 5'd0 || allow_hidden_use_of_x0);
            if (a_v) begin
                sel_rd_q <= sel_a;
                rd_q     <= data_a;
            end
            if (b_v) begin
                sel_rd2_q <= sel_b;
                rd2_q     <= data_b;
            end
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign busy_a    = sb_q[chk_sel_a] && (chk_sel_a != 5'd0 || allow_hidden_use_of_x0);
    assign busy_b    = sb_q[chk_sel_b] && (chk_sel_b != 5'd0 || allow_hidden_use_of_x0);
    assign sel_rd    = sel_rd_q;
    assign sel_rd2   = sel_rd2_q;
    assign rd        = rd_q;
    assign rd2       = rd2_q;
    assign write_rd  = write_rd_q;
    assign write_rd2 = write_rd2_q;
endmodule

// File: tb/tb_nanorv32_rf_wr_sched.sv
// tb_nanorv32_rf_wr_sched: directed vectors; expected write-port traffic is queued by the
// driver and checked by an independent monitor in the cycle it should appear.
module tb_nanorv32_rf_wr_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_sel;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        reserve_valid;
    logic [4:0]  reserve_sel, chk_sel_a, chk_sel_b;
    logic        busy_a, busy_b, allow_hidden_use_of_x0;
    logic [4:0]  sel_rd, sel_rd2;
    logic [31:0] rd, rd2;
    logic        write_rd, write_rd2;

    typedef struct {
        logic        w1;
        logic [4:0]  s1;
        logic [31:0] d1;
        logic        w2;
        logic [4:0]  s2;
        logic [31:0] d2;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    nanorv32_rf_wr_sched #(.NUM_REQ(3), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
        .req_ready(req_ready), .reserve_valid(reserve_valid), .reserve_sel(reserve_sel),
        .chk_sel_a(chk_sel_a), .chk_sel_b(chk_sel_b), .busy_a(busy_a), .busy_b(busy_b),
        .allow_hidden_use_of_x0(allow_hidden_use_of_x0), .sel_rd(sel_rd), .sel_rd2(sel_rd2),
        .rd(rd), .rd2(rd2), .write_rd(write_rd), .write_rd2(write_rd2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, want);
        end
    endtask

    function automatic exp_t mk(input logic w1, input logic [4:0] s1, input logic [31:0] d1,
                                input logic w2, input logic [4:0] s2, input logic [31:0] d2);
        exp_t e;
        e = '{w1, s1, d1, w2, s2, d2, 0};
        return e;
    endfunction

    function automatic exp_t idle();
        return mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input logic [2:0] v, input logic [4:0] s0, s1, s2,
                         input logic [31:0] d0, d1, d2, input logic rv, input logic [4:0] rs,
                         input logic [2:0] erdy, input exp_t e);
        req_valid     = v;
        req_sel       = {s2, s1, s0};
        req_data      = {d2, d1, d0};
        reserve_valid = rv;
        reserve_sel   = rs;
        #1;
        chk("req_ready", 32'(req_ready), 32'(erdy));
        e.tag = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'b000, idle());
    endtask

    task automatic bsy(input logic ea, input logic eb);
        chk("busy_a", 32'(busy_a), 32'(ea));
        chk("busy_b", 32'(busy_b), 32'(eb));
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_rd", 32'(write_rd), 32'(e.w1));
            chk("write_rd2", 32'(write_rd2), 32'(e.w2));
            if (e.w1) begin
                chk("sel_rd", 32'(sel_rd), 32'(e.s1));
                chk("rd", rd, e.d1);
            end
            if (e.w2) begin
                chk("sel_rd2", 32'(sel_rd2), 32'(e.s2));
                chk("rd2", rd2, e.d2);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = 3'b111;
        req_sel = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3, 32'h2, 32'h1};
        reserve_valid = 1'b0;
        reserve_sel = 5'd0;
        chk_sel_a = 5'd9;
        chk_sel_b = 5'd10;
        allow_hidden_use_of_x0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_write_rd", 32'(write_rd), 32'd0);
            chk("rst_write_rd2", 32'(write_rd2), 32'd0);
            bsy(1'b0, 1'b0);
        end
        rst = 1'b0;
        // single requester, no prior reservation
        drive(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001,
              mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0));
        drive(3'b100, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h44, 1'b0, 5'd0, 3'b100,
              mk(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0));
        // same-sel conflict: req1 skipped, pointer wraps back to 0
        drive(3'b111, 5'd3, 5'd3, 5'd7, 32'h30, 32'h31, 32'h72, 1'b0, 5'd0, 3'b101,
              mk(1'b1, 5'd3, 32'h30, 1'b1, 5'd7, 32'h72));
        drive(3'b011, 5'd10, 5'd3, 5'd0, 32'hA0, 32'h31, 32'd0, 1'b0, 5'd0, 3'b011,
              mk(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h31));
        drive(3'b100, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h80, 1'b0, 5'd0, 3'b100,
              mk(1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'd0));
        // round-robin fairness with all three held valid
        drive(3'b111, 5'd11, 5'd12, 5'd13, 32'hB, 32'hC, 32'hD, 1'b0, 5'd0, 3'b011,
              mk(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC));
        drive(3'b111, 5'd11, 5'd12, 5'd13, 32'hB, 32'hC, 32'hD, 1'b0, 5'd0, 3'b101,
              mk(1'b1, 5'd13, 32'hD, 1'b1, 5'd11, 32'hB));
        drive(3'b111, 5'd11, 5'd12, 5'd13, 32'hB, 32'hC, 32'hD, 1'b0, 5'd0, 3'b110,
              mk(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD));
        // scoreboard: reserve, write, clear two edges later
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9, 3'b000, idle());
        bsy(1'b1, 1'b0);
        drive(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001,
              mk(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0));
        bsy(1'b1, 1'b0);
        nop();
        bsy(1'b0, 1'b0);
        // re-reservation on the clearing edge keeps the reg busy
        chk_sel_b = 5'd9;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9, 3'b000, idle());
        bsy(1'b1, 1'b1);
        drive(3'b001, 5'd9, 5'd0, 5'd0, 32'h9A, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001,
              mk(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 32'd0));
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9, 3'b000, idle());
        bsy(1'b1, 1'b1);
        nop();
        bsy(1'b1, 1'b1);
        drive(3'b001, 5'd9, 5'd0, 5'd0, 32'h9B, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001,
              mk(1'b1, 5'd9, 32'h9B, 1'b0, 5'd0, 32'd0));
        nop();
        bsy(1'b0, 1'b0);
        // x0 writes: consumed but suppressed unless micro-rom mode
        chk_sel_a = 5'd0;
        drive(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001, idle());
        bsy(1'b0, 1'b0);
        allow_hidden_use_of_x0 = 1'b1;
        drive(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001,
              mk(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0));
        nop();
        allow_hidden_use_of_x0 = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expected transfers never checked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
